// File: rtl/line_pkg.sv
// line_pkg
//   Shared types and helpers for the 'line' serial receiver. The future
//   transmitter will use the same package.
//   Contents:
//     rx_state_t  receiver FSM states {IDLE, START, DATA, STOP}
//     calc_div    clocks per oversample tick, integer-truncated
package line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // The fractional remainder is dropped. The small baud error this causes is
  // absorbed by sampling at bit centres.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/line_byte_fifo.sv
// line_byte_fifo
//   Synchronous first-word-fall-through byte FIFO with an occupancy output.
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-high reset; empties the FIFO
//     push       in   write push_data (ignored when full unless popping)
//     push_data  in   8-bit byte to store
//     pop        in   remove head (ignored when empty)
//     head       out  current head byte, valid while !empty
//     empty      out  no bytes stored
//     full       out  DEPTH bytes stored
//     level      out  occupancy, 0..DEPTH
module line_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign level = count;
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy. Clearing the storage makes head read 0 after reset.
  // The pointers are AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/line_uart_rx.sv
// line_uart_rx
//   8N1 UART receiver for the 'line' serial signal (LSB first, idle high).
//   Each good frame is pushed into a FWFT byte FIFO. The FIFO drains through a
//   valid/ready stream.
//   Ports:
//     clk_clk        in   system clock
//     reset_reset    in   synchronous active-high reset
//     line_export    in   asynchronous serial line
//     rx_data        out  head-of-FIFO byte
//     rx_valid       out  FIFO not empty
//     rx_ready       in   consumer takes rx_data when rx_valid & rx_ready
//     rx_level       out  FIFO occupancy
//     framing_error  out  one-cycle pulse when a stop bit is sampled low
//     overrun        out  sticky; a byte arrived while the FIFO was full
//     overrun_clr    in   clears overrun (a simultaneous set wins)
module line_uart_rx
  import line_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          line_export,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          framing_error,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  rx_state_t        state;
  rx_state_t        state_next;

  logic             sync1;
  logic             sync2;
  logic             line_prev;
  logic             fall_edge;

  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             tick;
  logic             start_mid;
  logic             bit_sample;

  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

  logic             byte_done;
  logic             frame_bad;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             overrun_set;

  // Two flops bring the line into the clock domain. A third flop keeps the
  // previous synchronised value for edge detection. All reset to idle-high,
  // so a reset never produces a false start edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= line_export;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  assign fall_edge = line_prev & ~sync2;

  // The divider is held at zero in IDLE, so it restarts on entry to START.
  // os_cnt is re-zeroed at the start-bit centre. From then on, every wrap of
  // os_cnt lands on a bit centre.
  assign tick       = (div_cnt == DIV_LAST);
  assign start_mid  = (state == START) && tick && (os_cnt == OS_MID);
  assign bit_sample = ((state == DATA) || (state == STOP)) && tick && (os_cnt == OS_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset || state == IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (start_mid) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + 1'b1;
      end
    end
  end

  // Data bits are shifted in from the top, so after eight samples the first
  // (LSB) bit ends up in bit 0.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if (state == DATA && bit_sample) begin
      shift_reg <= {sync2, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start bit that is already high again at its centre
  // is treated as a glitch and dropped silently.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall_edge) state_next = START;
      START:   if (start_mid) state_next = sync2 ? IDLE : DATA;
      DATA:    if (bit_sample && bit_cnt == 3'd7) state_next = STOP;
      STOP:    if (bit_sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode at the stop-bit centre
  always_comb begin
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (state == STOP && bit_sample) begin
      if (sync2) begin
        byte_done = 1'b1;
      end else begin
        frame_bad = 1'b1;
      end
    end
  end

  // A simultaneous pop makes room, so a byte that arrives while the FIFO is
  // full is still kept in that case and is not an overrun.
  assign fifo_pop    = rx_valid & rx_ready;
  assign fifo_push   = byte_done & (~fifo_full | fifo_pop);
  assign overrun_set = byte_done & fifo_full & ~fifo_pop;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  line_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (fifo_pop),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (rx_level)
  );

  assign rx_valid = ~fifo_empty;

endmodule
